// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result bundle for the bit-serial adder sequencer.
// With SERIAL_ADD_OVF_EN defined the bundle also carries the signed-overflow flag ovf.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
    modport master(output start, sub, a_in, b_in, cin, input busy, done, sum, cout, ovf);
    modport slave(input start, sub, a_in, b_in, cin, output busy, done, sum, cout, ovf);
`else
    modport master(output start, sub, a_in, b_in, cin, input busy, done, sum, cout);
    modport slave(input start, sub, a_in, b_in, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add/subtract time-sharing one full-adder cell, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, res, res_nx, sum;
    logic [CW-1:0]    cnt;
    logic             carry, carry_nx, s, last, accept, busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
    assign bus.ovf = ovf;
`endif
    assign s        = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nx = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign res_nx   = {s, res[WIDTH-1:1]};
    assign last     = cnt == CW'(WIDTH - 1);
    assign accept   = bus.start && state != RUN;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum;
    assign bus.cout = cout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = IDLE;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            RUN: begin
                busy     = 1'b1;
                state_nx = last ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: state_nx = bus.start ? RUN : IDLE;
        endcase
    end
    // Subtraction is a + ~b + 1, so inversion and forced carry happen at load time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= bus.a_in;
            b_sr  <= bus.sub ? ~bus.b_in : bus.b_in;
            carry <= bus.sub | bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= carry_nx;
            res   <= res_nx;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res_nx;
                cout <= carry_nx;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= carry ^ carry_nx;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random stimulus checked every cycle against an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    serial_add_ctrl_if #(.WIDTH(W)) bus();
    serial_add_ctrl #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int           left;
    logic         m_done, m_cout, m_ovf;
    logic [W-1:0] m_sum;
    logic [W+1:0] pend;

    function automatic logic [W+1:0] calc(input logic [W-1:0] a, b, input logic c, s);
        logic [W-1:0] bb;
        logic [W:0]   t;
        logic         o;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + (W+1)'(s | c);
        o  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return {o, t};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: an accepted op stays busy for W cycles, then publishes its result for one cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left   <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (left != 0) begin
            left <= left - 1;
            if (left == 1) begin
                m_done <= 1'b1;
                {m_ovf, m_cout, m_sum} <= pend;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                left <= W;
                pend <= calc(bus.a_in, bus.b_in, bus.cin, bus.sub);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", bus.busy, left != 0);
        check("done", bus.done, m_done);
        check("sum", bus.sum, m_sum);
        check("cout", bus.cout, m_cout);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", bus.ovf, m_ovf);
`endif
    end

    task automatic run_op(input logic [W-1:0] a, b, input logic c, s, input logic [W-1:0] es,
                          input logic ec, eo, input bit mid, input string nm);
        int n;
        @(negedge clk);
        bus.a_in = a; bus.b_in = b; bus.cin = c; bus.sub = s; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < W + 4) begin
            if (mid && n == 3) begin
                bus.start = 1'b1; bus.a_in = ~a; bus.b_in = 8'h5A; bus.sub = ~s;
            end else bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({nm, "_lat"}, n, W);
        check({nm, "_sum"}, bus.sum, es);
        check({nm, "_cout"}, bus.cout, ec);
        check({nm, "_model"}, {m_cout, m_sum}, {ec, es});
`ifdef SERIAL_ADD_OVF_EN
        check({nm, "_ovf"}, bus.ovf, eo);
`else
        if (eo === 1'bx) $display("unused ovf expectation");
`endif
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a_in = '0; bus.b_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_sum", bus.sum, 0);
        run_op(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 0, "add_0f_01");
        run_op(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 0, "add_ff_01");
        run_op(8'h00, 8'h00, 1, 0, 8'h01, 0, 0, 0, "add_cin");
        run_op(8'h05, 8'h07, 1, 1, 8'hFE, 0, 0, 0, "sub_05_07");
        run_op(8'h07, 8'h05, 0, 1, 8'h02, 1, 0, 0, "sub_07_05");
        run_op(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0, "ovf_7f_01");
        run_op(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 0, "ovf_ff_01");
        run_op(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 0, "ovf_sub_80_01");
        run_op(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 1, "mid_start");
        // Start held high: accepted straight out of DONE every W+1 cycles.
        @(negedge clk);
        bus.a_in = 8'h10; bus.b_in = 8'h20; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        n = 0;
        while (!bus.done && n < 2 * W) begin @(negedge clk); n++; end
        check("b2b_first", bus.done, 1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.done && n < 2 * W);
            check("b2b_gap", n, W + 1);
            check("b2b_sum", bus.sum, 8'h30);
        end
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);
        // Asynchronous reset in the middle of RUN.
        bus.a_in = 8'h33; bus.b_in = 8'h44; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 0, 0, 8'h02, 0, 0, 0, "post_rst");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start = $urandom_range(0, 2) == 0;
            bus.a_in  = W'($urandom);
            bus.b_in  = W'($urandom);
            bus.cin   = 1'($urandom);
            bus.sub   = 1'($urandom);
        end
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer that performs a WIDTH-bit add or subtract by time-sharing a single 1-bit full-adder cell over WIDTH clock cycles, LSB first. It accepts operands on a start handshake, shifts them through the cell one bit per cycle, threads the carry through a register, and presents the registered result with a one-cycle done pulse. It is the bit-serial front end for the team's full-adder datapath.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request to begin an operation; sampled only in IDLE or DONE.
sub  input  1  0 = a + b + cin, 1 = a - b (b inverted, carry-in forced to 1, cin ignored); sampled with start.
a_in  input  WIDTH  operand A; sampled with start.
b_in  input  WIDTH  operand B; sampled with start.
cin  input  1  carry-in for add; sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
sum  output  WIDTH  last completed result; held until the next completion.
cout  output  1  carry-out of the last completed operation; for sub, 1 = no borrow.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry and bit counter cleared. Asynchronous assertion aborts any operation in flight, with no done pulse. Deassertion takes effect on the next clk edge.
- FSM has three states: IDLE, RUN and DONE.
- IDLE: if start=1, latch a_in into the A shift register and b_in (or ~b_in if sub=1) into the B shift register. Load carry with cin (or 1 if sub=1), clear the counter, go to RUN.
- RUN, one bit per cycle:
  - s = A[0]^B[0]^carry; carry <= majority(A[0], B[0], carry).
  - A and B shift right by 1; s shifts into the MSB of the internal result register.
  - counter increments.
  - When counter reaches WIDTH-1 on this edge, go to DONE. On the same edge: sum <= final result register contents, cout <= final carry, done <= 1.
- DONE: lasts exactly one cycle (done=1, busy=0), then goes to IDLE. A start sampled in DONE is accepted exactly as in IDLE, going directly to RUN, so back-to-back operations are allowed.
- Latency: start sampled at edge 0 -> busy high for WIDTH cycles -> done high in cycle WIDTH+1 after the accepting edge. Throughput is one result per WIDTH+1 cycles.
- start in RUN is ignored. Operand or sub changes during RUN have no effect.
- sum and cout change only on the done edge. They never show partial results.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB goes to cout only.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), updated on the done edge with the two's-complement signed overflow = carry into MSB XOR carry out of MSB; held like sum.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high with start=0 for 10 cycles -> busy=0, done=0, sum=0x00, cout=0 throughout.
- Add (WIDTH=8): a=0x0F, b=0x01, cin=0, sub=0, start for 1 cycle -> busy for 8 cycles, done in cycle 9, sum=0x10, cout=0. Then a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01.
- Subtract: a=0x05, b=0x07, sub=1, cin=1 (ignored) -> sum=0xFE, cout=0. Then a=0x07, b=0x05 -> sum=0x02, cout=1.
- Handshake: start held high continuously with a=0x10, b=0x20 -> done pulses every 9 cycles, sum=0x30. A start pulse mid-RUN with other operands has no effect on the result or timing.
- Reset mid-operation: assert rst_n low at RUN cycle 4 -> busy, done, sum and cout drop to 0 immediately. After release, a new op a=0x01, b=0x01 -> sum=0x02.
- With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1. Then a=0xFF, b=0x01 -> ovf=0, cout=1. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
